// File: rtl/deny_move_scan.sv
// Sequential wall-deny scanner: walks every grid cell under the player box through a
// synchronous wall-map port and reports one deny verdict. Optional macro: DENY_SCAN_EARLY_EXIT_EN.
module deny_move_scan #(
  parameter int unsigned SIZE_Y     = 20,
  parameter int unsigned SIZE_X     = 40,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned ADDR_W     = $clog2(SIZE_Y * SIZE_X)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [1:0]        dir,
  input  logic [9:0]        top,
  input  logic [9:0]        bottom,
  input  logic [9:0]        left,
  input  logic [9:0]        right,
  output logic              cell_rd_en,
  output logic [ADDR_W-1:0] cell_addr,
  input  logic [3:0]        cell_walls,
  output logic              busy,
  output logic              done,
  output logic              deny
);

  localparam int unsigned PIX_W = 10;
  localparam int unsigned IDX_W = PIX_W - CELL_SHIFT;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        r_state;
  logic [1:0]        r_dir;
  logic [PIX_W-1:0]  r_top;
  logic [PIX_W-1:0]  r_bottom;
  logic [PIX_W-1:0]  r_left;
  logic [PIX_W-1:0]  r_right;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_base;
  logic              r_acc;
  logic              r_vld;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic              r_busy;
  logic              r_done;
  logic              r_deny;

  logic [2:0]        w_state_nxt;
  logic              w_latch;
  logic [IDX_W-1:0]  w_row_nxt;
  logic [IDX_W-1:0]  w_col_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic              w_acc_nxt;
  logic              w_rd_en_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_done_nxt;
  logic              w_deny_nxt;

  logic [IDX_W-1:0]  w_row0;
  logic [IDX_W-1:0]  w_row1;
  logic [IDX_W-1:0]  w_col0;
  logic [IDX_W-1:0]  w_col1;
  logic              w_invalid;
  logic              w_edge;
  logic              w_hit;

  // Pixel coordinate to cell index, clamped to the last row/column of the grid.
  function automatic logic [IDX_W-1:0] clamp_idx(input logic [PIX_W-1:0] pix,
                                                 input int unsigned lim);
    logic [IDX_W-1:0] idx;
    idx = pix[PIX_W-1:CELL_SHIFT];
    if (32'(idx) > (lim - 1)) begin
      return IDX_W'(lim - 1);
    end
    return idx;
  endfunction

  assign w_row0    = clamp_idx(r_top, SIZE_Y);
  assign w_row1    = clamp_idx(r_bottom, SIZE_Y);
  assign w_col0    = clamp_idx(r_left, SIZE_X);
  assign w_col1    = clamp_idx(r_right, SIZE_X);
  assign w_invalid = (r_left > r_right) || (r_top > r_bottom);
  assign w_hit     = r_vld & cell_walls[r_dir];

  // Box already flush against the screen edge in the move direction.
  always_comb begin
    w_edge = 1'b0;
    case (r_dir)
      DIR_UP:    w_edge = (r_top == '0);
      DIR_DOWN:  w_edge = (w_row1 == IDX_W'(SIZE_Y - 1)) && (&r_bottom[CELL_SHIFT-1:0]);
      DIR_LEFT:  w_edge = (r_left == '0);
      DIR_RIGHT: w_edge = (w_col1 == IDX_W'(SIZE_X - 1)) && (&r_right[CELL_SHIFT-1:0]);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_base_nxt  = r_base;
    w_acc_nxt   = r_acc | w_hit;
    w_rd_en_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_done_nxt  = 1'b0;
    w_deny_nxt  = r_deny;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (w_invalid || w_edge) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
          w_deny_nxt  = 1'b1;
        end else begin
          // Constant multiply happens once here, off the per-cell address path.
          w_state_nxt = ST_SCAN;
          w_acc_nxt   = 1'b0;
          w_row_nxt   = w_row0;
          w_col_nxt   = w_col0;
          w_base_nxt  = ADDR_W'(32'(w_row0) * SIZE_X);
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = ADDR_W'(32'(w_row0) * SIZE_X) + ADDR_W'(w_col0);
        end
      end

      ST_SCAN: begin
        if (r_col == w_col1) begin
          if (r_row == w_row1) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_row_nxt   = r_row + IDX_W'(1);
            w_col_nxt   = w_col0;
            w_base_nxt  = r_base + ADDR_W'(SIZE_X);
            w_rd_en_nxt = 1'b1;
            w_addr_nxt  = r_base + ADDR_W'(SIZE_X) + ADDR_W'(w_col0);
          end
        end else begin
          w_col_nxt   = r_col + IDX_W'(1);
          w_rd_en_nxt = 1'b1;
          w_addr_nxt  = r_addr + ADDR_W'(1);
        end
`ifdef DENY_SCAN_EARLY_EXIT_EN
        if (w_hit) begin
          w_state_nxt = ST_DONE;
          w_rd_en_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_deny_nxt  = 1'b1;
        end
`endif
      end

      ST_DRAIN: begin
        w_state_nxt = ST_DONE;
        w_done_nxt  = 1'b1;
        w_deny_nxt  = r_acc | w_hit;
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, scan counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= ST_IDLE;
      r_dir    <= '0;
      r_top    <= '0;
      r_bottom <= '0;
      r_left   <= '0;
      r_right  <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_base   <= '0;
      r_acc    <= 1'b0;
      r_vld    <= 1'b0;
      r_rd_en  <= 1'b0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_deny   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_dir    <= dir;
        r_top    <= top;
        r_bottom <= bottom;
        r_left   <= left;
        r_right  <= right;
      end
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_base  <= w_base_nxt;
      r_acc   <= w_acc_nxt;
      r_vld   <= r_rd_en;
      r_rd_en <= w_rd_en_nxt;
      r_addr  <= w_addr_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= w_done_nxt;
      r_deny  <= w_deny_nxt;
    end
  end

  assign cell_rd_en = r_rd_en;
  assign cell_addr  = r_addr;
  assign busy       = r_busy;
  assign done       = r_done;
  assign deny       = r_deny;

endmodule

// File: tb/tb_deny_move_scan.sv
// Bench for deny_move_scan: directed vector table, hand-written reset/lockout sequences,
// and randomized boxes against a cell-list reference model with a behavioural wall map.
module tb_deny_move_scan;

  localparam int SY    = 20;
  localparam int SX    = 40;
  localparam int NCELL = SY * SX;
  localparam int MAXC  = 2000;

  logic       Clk;
  logic       Reset_n;
  logic       start;
  logic [1:0] dir;
  logic [9:0] top, bottom, left, right;
  logic       cell_rd_en;
  logic [9:0] cell_addr;
  logic [3:0] cell_walls;
  logic       busy, done, deny;

  deny_move_scan dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .dir        (dir),
    .top        (top),
    .bottom     (bottom),
    .left       (left),
    .right      (right),
    .cell_rd_en (cell_rd_en),
    .cell_addr  (cell_addr),
    .cell_walls (cell_walls),
    .busy       (busy),
    .done       (done),
    .deny       (deny)
  );

  logic [3:0] mem [0:NCELL-1];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous wall map; garbage on idle cycles so stray samples get noticed.
  always @(posedge Clk) begin
    if (cell_rd_en && (int'(cell_addr) < NCELL)) cell_walls <= mem[cell_addr];
    else                                         cell_walls <= 4'($urandom);
  end

  int tests;
  int fails;
  int got_addrs[$];
  int exp_addrs[$];
  int got_done_cyc;
  int got_done_cnt;
  int got_deny;
  int busy_bad;

  typedef struct {
    logic [1:0] d;
    int t, b, l, r;
    int waddr, wbit;
    int e_deny, e_done, e_n, e_first;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Reference: list of covered cells in row-major order, OR of the chosen wall bit.
  task automatic model(input logic [1:0] d, input int t, input int b, input int l, input int r,
                       output int e_done, output int e_deny);
    int r0, r1, c0, c1;
    bit at_edge;
    exp_addrs.delete();
    r0 = clampi(t / 16, SY - 1);
    r1 = clampi(b / 16, SY - 1);
    c0 = clampi(l / 16, SX - 1);
    c1 = clampi(r / 16, SX - 1);
    case (d)
      2'd0:    at_edge = (t == 0);
      2'd1:    at_edge = (r1 == SY - 1) && (b % 16 == 15);
      2'd2:    at_edge = (l == 0);
      default: at_edge = (c1 == SX - 1) && (r % 16 == 15);
    endcase
    if ((l > r) || (t > b) || at_edge) begin
      e_done = 2;
      e_deny = 1;
      return;
    end
    e_deny = 0;
    for (int rr = r0; rr <= r1; rr++) begin
      for (int cc = c0; cc <= c1; cc++) begin
        exp_addrs.push_back(rr * SX + cc);
        if (mem[rr * SX + cc][d]) e_deny = 1;
      end
    end
    e_done = exp_addrs.size() + 3;
  endtask

  // Pulse start (held for cycles 1..hold_start too), scramble inputs afterwards, collect outputs.
  task automatic run_txn(input logic [1:0] d, input int t, input int b, input int l, input int r,
                         input int hold_start);
    got_addrs.delete();
    got_done_cyc = -1;
    got_done_cnt = 0;
    got_deny     = -1;
    busy_bad     = 0;
    @(negedge Clk);
    dir = d; top = 10'(t); bottom = 10'(b); left = 10'(l); right = 10'(r);
    start = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge Clk);
      start  = (c <= hold_start);
      dir    = 2'($urandom);
      top    = 10'($urandom);
      bottom = 10'($urandom);
      left   = 10'($urandom);
      right  = 10'($urandom);
      if (cell_rd_en) got_addrs.push_back(int'(cell_addr));
      if (done) begin
        got_done_cnt++;
        if (got_done_cyc < 0) begin
          got_done_cyc = c;
          got_deny     = int'(deny);
        end
      end
      if ((got_done_cyc < 0) || (c == got_done_cyc)) begin
        if (!busy) busy_bad++;
      end else if (busy) begin
        busy_bad++;
      end
      if ((got_done_cyc >= 0) && (c >= got_done_cyc + 3) && (c > hold_start)) break;
    end
    start = 1'b0;
  endtask

  task automatic check_addrs(input string tag);
    int mism;
    mism = -1;
    check({tag, "_nreads"}, got_addrs.size(), exp_addrs.size());
    for (int i = 0; i < got_addrs.size() && i < exp_addrs.size(); i++) begin
      if ((mism < 0) && (got_addrs[i] != exp_addrs[i])) mism = i;
    end
    check({tag, "_addr_mismatch_idx"}, mism, -1);
  endtask

  initial begin
    int e_done, e_deny, t, b, l, r, mode;
    logic [1:0] d;
    tests = 0;
    fails = 0;
    Reset_n = 1'b0; start = 1'b0; dir = '0;
    top = '0; bottom = '0; left = '0; right = '0;
    cell_walls = '0;
    for (int i = 0; i < NCELL; i++) mem[i] = '0;

    vecs[0]  = '{2'd2,  32,   47,  64,   79,  -1, 0, 0, 4, 1,  84};
    vecs[1]  = '{2'd2,  32,   47,  60,   79,  84, 2, 1, 5, 2,  83};
    vecs[2]  = '{2'd2,  32,   47,  60,   79,  84, 3, 0, 5, 2,  83};
    vecs[3]  = '{2'd2,  32,   47,   0,   15,  -1, 0, 1, 2, 0,  -1};
    vecs[4]  = '{2'd2,  32,   47,  50,   40,  -1, 0, 1, 2, 0,  -1};
    vecs[5]  = '{2'd3, 304, 1023, 624, 1023,  -1, 0, 1, 2, 0,  -1};
    vecs[6]  = '{2'd0, 304, 1023, 624, 1023,  -1, 0, 0, 4, 1, 799};
    vecs[7]  = '{2'd0,   0,   15,  64,   79,  -1, 0, 1, 2, 0,  -1};
    vecs[8]  = '{2'd1, 300,  318,  64,   79, 764, 1, 1, 5, 2, 724};
    vecs[9]  = '{2'd1, 300,  319,  64,   79,  -1, 0, 1, 2, 0,  -1};
    vecs[10] = '{2'd3,  32,   63,  64,   95,  84, 3, 1, 7, 4,  84};

    // Reset values
    repeat (2) @(negedge Clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_deny", int'(deny), 0);
    check("rst_rd_en", int'(cell_rd_en), 0);
    check("rst_addr", int'(cell_addr), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Directed vector table
    foreach (vecs[k]) begin
      for (int i = 0; i < NCELL; i++) mem[i] = '0;
      if (vecs[k].waddr >= 0) mem[vecs[k].waddr][vecs[k].wbit] = 1'b1;
      run_txn(vecs[k].d, vecs[k].t, vecs[k].b, vecs[k].l, vecs[k].r, 0);
      check($sformatf("vec%0d_deny", k), got_deny, vecs[k].e_deny);
      check($sformatf("vec%0d_done_cycle", k), got_done_cyc, vecs[k].e_done);
      check($sformatf("vec%0d_nreads", k), got_addrs.size(), vecs[k].e_n);
      check($sformatf("vec%0d_done_pulses", k), got_done_cnt, 1);
      check($sformatf("vec%0d_busy", k), busy_bad, 0);
      if (vecs[k].e_first >= 0 && got_addrs.size() > 0)
        check($sformatf("vec%0d_first_addr", k), got_addrs[0], vecs[k].e_first);
    end

    // Busy lockout: start re-pulsed in cycles 1..4 of a 4-cell scan
    for (int i = 0; i < NCELL; i++) mem[i] = '0;
    mem[125][2] = 1'b1;
    run_txn(2'd2, 32, 63, 64, 95, 4);
    check("lockout_done_cycle", got_done_cyc, 7);
    check("lockout_done_pulses", got_done_cnt, 1);
    check("lockout_deny", got_deny, 1);
    check("lockout_nreads", got_addrs.size(), 4);

    // Reset mid-scan on a 2x2 box
    @(negedge Clk);
    dir = 2'd2; top = 10'd32; bottom = 10'd63; left = 10'd64; right = 10'd95;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    check("midrst_rd_before", int'(cell_rd_en), 1);
    Reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_rd_en", int'(cell_rd_en), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    got_done_cnt = 0;
    busy_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      if (done) got_done_cnt++;
      if (busy || cell_rd_en) busy_bad++;
    end
    check("midrst_no_done", got_done_cnt, 0);
    check("midrst_idle", busy_bad, 0);

    // Randomized boxes and wall maps against the reference model
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < NCELL; i++)
        mem[i] = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
      d = 2'($urandom);
      t = $urandom_range(0, 330);
      b = t + $urandom_range(0, 40);
      l = $urandom_range(0, 660);
      r = l + $urandom_range(0, 50);
      mode = $urandom_range(0, 7);
      case (mode)
        0: begin l = r + 1; end
        1: begin t = 0; l = 0; end
        2: begin b = 1023; r = 1023; t = 300; l = 620; end
        3: begin b = 319; r = 639; end
        default: ;
      endcase
      b = clampi(b, 1023);
      r = clampi(r, 1023);
      l = clampi(l, 1023);
      model(d, t, b, l, r, e_done, e_deny);
      run_txn(d, t, b, l, r, $urandom_range(0, 1));
      check($sformatf("rnd%0d_deny", n), got_deny, e_deny);
      check($sformatf("rnd%0d_done_cycle", n), got_done_cyc, e_done);
      check($sformatf("rnd%0d_done_pulses", n), got_done_cnt, 1);
      check($sformatf("rnd%0d_busy", n), busy_bad, 0);
      check_addrs($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deny_move_scan.md
Name: deny_move_scan

Overview:
- Sequential, direction-generic successor to the per-direction combinational wall-deny logic in the maze game.
- On a start pulse, latches the player bounding box and a requested move direction (up/down/left/right). It then scans every maze grid cell overlapped by the box, one cell per clock, through a synchronous wall-map read port.
- Reports a single deny verdict with a done pulse. Sits between player movement control and the wall-map RAM/ROM, replacing the size_y*size_x parallel comparator array.

Parameters:
- SIZE_Y, 20, grid rows.
- SIZE_X, 40, grid columns.
- CELL_SHIFT, 4, log2 of cell edge in pixels (cells are 16x16 px).
- ADDR_W, $clog2(SIZE_Y*SIZE_X), wall-map address width.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request pulse; ignored while busy=1.
- dir  in  2  0=up, 1=down, 2=left, 3=right; sampled with start.
- top, bottom, left, right  in  10 each  pixel bounding box, inclusive; sampled with start.
- cell_rd_en  out  1  wall-map read strobe.
- cell_addr  out  ADDR_W  row*SIZE_X+col.
- cell_walls  in  4  wall bits of the addressed cell, valid exactly 1 cycle after cell_rd_en; [0]=up [1]=down [2]=left [3]=right.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse; deny is valid in this cycle.
- deny  out  1  registered verdict; holds until the next done.

Behaviour:
- Reset (async, Reset_n=0) forces state IDLE and clears busy, done, deny, cell_rd_en and cell_addr to 0. Reset asserted mid-scan aborts the scan with no done pulse.
- Cell ranges: col0=left>>CELL_SHIFT, col1=right>>CELL_SHIFT, row0=top>>CELL_SHIFT, row1=bottom>>CELL_SHIFT.
  - Any index beyond the grid clamps to SIZE_X-1 or SIZE_Y-1.
  - The address is formed from the row and column counters; no multiply on the critical path (row base is accumulated by +SIZE_X).
- States:
  - IDLE: on start, latch inputs and go to CHECK.
  - CHECK (1 cycle): go directly to DONE with deny=1 if the box is invalid (left>right or top>bottom) or it touches the screen edge in the move direction (up: top==0; left: left==0; down: row1 at or beyond SIZE_Y-1 with bottom[CELL_SHIFT-1:0] all 1s; right: the same for col1/SIZE_X-1). Otherwise clear the accumulator and go to SCAN.
  - SCAN: one cell_rd_en per cycle, row-major from (row0,col0) to (row1,col1). After the last address go to DRAIN.
  - DRAIN (1 cycle): absorb the final returned cell_walls.
  - DONE (1 cycle): done=1 and deny=accumulator, then return to IDLE.
- Accumulator ORs cell_walls[dir] on every cycle following a cell_rd_en.
- Latency: start at cycle 0, CHECK at cycle 1, first cell_rd_en at cycle 2. For N cells, done occurs at cycle N+3. An edge/invalid deny gives done at cycle 2.
- start in the same cycle as done is ignored; start is accepted only in IDLE.
- Input changes after the start cycle have no effect on an active scan.
- busy=1 in CHECK, SCAN, DRAIN and DONE.

Optional Feature:
- Macro DENY_SCAN_EARLY_EXIT_EN.
- Defined: on the first returned cell_walls[dir]=1, cell_rd_en drops immediately and the block goes straight to DONE the next cycle with deny=1. The read data for any in-flight address is discarded.
- Undefined: the full cell range is always scanned, giving a fixed latency of N+3.

Test Plan:
- Reset mid-scan: start a 2x2-cell box, pull Reset_n low at cycle 3 -> busy, done and cell_rd_en are 0 within the same cycle; no done pulse follows.
- Open space: box top=32, bottom=47, left=64, right=79, dir=2, all wall bits 0 -> single cell addr 2*40+4=84 read at cycle 2; done at cycle 4 with deny=0.
- Wall hit: box left=60, right=79, top=32, bottom=47, dir=2, cell 84 has bit[2]=1 -> addresses 83, 84 issued; deny=1 at cycle 5. With EARLY_EXIT_EN, done occurs at cycle 5 and no extra reads are issued.
- Edge deny: left=0, dir=2 -> no cell_rd_en; done at cycle 2 with deny=1. Also invalid box left=50, right=40 -> deny=1 at cycle 2.
- Clamp: right=1023, bottom=1023, top=304, left=624, dir=3 -> col1 and row1 clamp to 39 and 19; edge deny=1 at cycle 2. With dir=0, the single address 799 is scanned.
- Busy lockout: start re-pulsed at cycles 1–4 during a 4-cell scan -> ignored; exactly one done pulse, at cycle 7.
